// File: rtl/frame_buf_sched.sv
// frame_buf_sched: triple-buffer burst scheduler that shares one HyperRAM
// user port between the camera write FIFO and the display read FIFO.
module frame_buf_sched #(
   parameter int BURST_WORDS = 32,
   parameter int FRAME_WORDS = 76800,
   parameter int OFF_W       = 20,
   parameter int FIFO_W      = 10,
   parameter int WR_URGENT   = 256
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_init_done,
   input  logic              I_wr_frame_start,
   input  logic              I_rd_frame_start,
   input  logic [FIFO_W-1:0] I_wr_fifo_level,
   input  logic [FIFO_W-1:0] I_rd_fifo_free,
   output logic              O_cmd_en,
   output logic              O_cmd,
   output logic [OFF_W+1:0]  O_addr,
   input  logic              I_cmd_done,
   output logic              O_wr_grant,
   output logic              O_rd_grant,
   output logic [1:0]        O_wr_bank,
   output logic [1:0]        O_rd_bank,
   output logic              O_overrun
);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   localparam logic [FIFO_W-1:0] LVL_BURST = FIFO_W'(BURST_WORDS);
   localparam logic [FIFO_W-1:0] LVL_URG   = FIFO_W'(WR_URGENT);
   localparam logic [OFF_W-1:0]  OFF_STEP  = OFF_W'(BURST_WORDS);
   localparam logic [OFF_W:0]    OFF_END   = (OFF_W+1)'(FRAME_WORDS);

   state_t           state_q, state_d;
   logic [1:0]       wr_bank_q, wr_bank_d;
   logic [1:0]       rd_bank_q, rd_bank_d;
   logic [1:0]       done_bank_q, done_bank_d;
   logic [OFF_W-1:0] wr_off_q, wr_off_d;
   logic [OFF_W-1:0] rd_off_q, rd_off_d;
   logic             wr_act_q, wr_act_d;
   logic             rd_act_q, rd_act_d;
   logic             wr_pend_q, wr_pend_d;
   logic             rd_pend_q, rd_pend_d;
   logic             last_wr_q, last_wr_d;
   logic             side_wr_q, side_wr_d;

   logic             wr_ok, rd_ok, urgent;
   logic             grant_wr, grant_rd, apply;
   logic [1:0]       new_rd, wr_pick;
   logic [OFF_W-1:0] cur_off;
   logic [OFF_W:0]   off_sum;

   assign wr_ok    = wr_act_q & (I_wr_fifo_level >= LVL_BURST);
   assign rd_ok    = rd_act_q & (I_rd_fifo_free >= LVL_BURST);
   assign urgent   = wr_ok & (I_wr_fifo_level >= LVL_URG);
   assign grant_wr = urgent | (wr_ok & ~rd_ok) | (wr_ok & rd_ok & ~last_wr_q);
   assign grant_rd = rd_ok & ~grant_wr;
   assign apply    = wr_pend_q | rd_pend_q;

   // Write bank must avoid both the bank on screen and the newest full frame.
   assign new_rd  = rd_pend_q ? done_bank_q : rd_bank_q;
   assign wr_pick = (new_rd == done_bank_q)
                  ? ((done_bank_q == 2'd2) ? 2'd0 : done_bank_q + 2'd1)
                  : 2'(2'd3 - new_rd - done_bank_q);

   assign cur_off = side_wr_q ? wr_off_q : rd_off_q;
   assign off_sum = {1'b0, cur_off} + {1'b0, OFF_STEP};

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q     <= S_INIT;
         wr_bank_q   <= 2'd1;
         rd_bank_q   <= 2'd0;
         done_bank_q <= 2'd0;
         wr_off_q    <= '0;
         rd_off_q    <= '0;
         wr_act_q    <= 1'b0;
         rd_act_q    <= 1'b0;
         wr_pend_q   <= 1'b0;
         rd_pend_q   <= 1'b0;
         last_wr_q   <= 1'b0;
         side_wr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         done_bank_q <= done_bank_d;
         wr_off_q    <= wr_off_d;
         rd_off_q    <= rd_off_d;
         wr_act_q    <= wr_act_d;
         rd_act_q    <= rd_act_d;
         wr_pend_q   <= wr_pend_d;
         rd_pend_q   <= rd_pend_d;
         last_wr_q   <= last_wr_d;
         side_wr_q   <= side_wr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      done_bank_d = done_bank_q;
      wr_off_d    = wr_off_q;
      rd_off_d    = rd_off_q;
      wr_act_d    = wr_act_q;
      rd_act_d    = rd_act_q;
      wr_pend_d   = wr_pend_q | I_wr_frame_start;
      rd_pend_d   = rd_pend_q | I_rd_frame_start;
      last_wr_d   = last_wr_q;
      side_wr_d   = side_wr_q;
      unique case (state_q)
         S_INIT: begin
            if (I_init_done) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (apply) begin
               if (rd_pend_q) begin
                  rd_bank_d = done_bank_q;
                  rd_off_d  = '0;
                  rd_act_d  = 1'b1;
                  rd_pend_d = 1'b0;
               end
               if (wr_pend_q) begin
                  wr_bank_d = wr_pick;
                  wr_off_d  = '0;
                  wr_act_d  = 1'b1;
                  wr_pend_d = 1'b0;
               end
            end else if (grant_wr | grant_rd) begin
               side_wr_d = grant_wr;
               last_wr_d = grant_wr;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (I_cmd_done) begin
               state_d = S_IDLE;
               if (side_wr_q) begin
                  if (off_sum == OFF_END) begin
                     wr_off_d    = '0;
                     wr_act_d    = 1'b0;
                     done_bank_d = wr_bank_q;
                  end else begin
                     wr_off_d = off_sum[OFF_W-1:0];
                  end
               end else begin
                  if (off_sum == OFF_END) begin
                     rd_off_d = '0;
                     rd_act_d = 1'b0;
                  end else begin
                     rd_off_d = off_sum[OFF_W-1:0];
                  end
               end
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_comb begin
      O_cmd_en   = 1'b0;
      O_cmd      = 1'b0;
      O_addr     = '0;
      O_wr_grant = 1'b0;
      O_rd_grant = 1'b0;
      O_overrun  = 1'b0;
      O_wr_bank  = wr_bank_q;
      O_rd_bank  = rd_bank_q;
      if (state_q == S_ISSUE || state_q == S_WAIT) begin
         O_cmd_en   = (state_q == S_ISSUE);
         O_cmd      = side_wr_q;
         O_wr_grant = side_wr_q;
         O_rd_grant = ~side_wr_q;
         O_addr     = side_wr_q ? {wr_bank_q, wr_off_q}
                                : {rd_bank_q, rd_off_q};
      end
      // Restart of a camera frame that never finished writing.
      if (state_q == S_IDLE && wr_pend_q && wr_act_q) O_overrun = 1'b1;
   end

endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: scoreboard bench for frame_buf_sched with a
// frame-level reference model and a fixed-latency controller model.
module tb_frame_buf_sched;

   localparam int BW  = 16;
   localparam int FW  = 64;
   localparam int OW  = 6;
   localparam int FWD = 10;
   localparam int URG = 48;

   logic           I_clk = 1'b0;
   logic           I_rst;
   logic           I_init_done;
   logic           I_wr_frame_start;
   logic           I_rd_frame_start;
   logic [FWD-1:0] I_wr_fifo_level;
   logic [FWD-1:0] I_rd_fifo_free;
   logic           O_cmd_en;
   logic           O_cmd;
   logic [OW+1:0]  O_addr;
   logic           I_cmd_done;
   logic           O_wr_grant;
   logic           O_rd_grant;
   logic [1:0]     O_wr_bank;
   logic [1:0]     O_rd_bank;
   logic           O_overrun;

   always #5 I_clk = ~I_clk;

   frame_buf_sched #(
      .BURST_WORDS(BW),
      .FRAME_WORDS(FW),
      .OFF_W(OW),
      .FIFO_W(FWD),
      .WR_URGENT(URG)
   ) dut (
      .I_clk(I_clk),
      .I_rst(I_rst),
      .I_init_done(I_init_done),
      .I_wr_frame_start(I_wr_frame_start),
      .I_rd_frame_start(I_rd_frame_start),
      .I_wr_fifo_level(I_wr_fifo_level),
      .I_rd_fifo_free(I_rd_fifo_free),
      .O_cmd_en(O_cmd_en),
      .O_cmd(O_cmd),
      .O_addr(O_addr),
      .I_cmd_done(I_cmd_done),
      .O_wr_grant(O_wr_grant),
      .O_rd_grant(O_rd_grant),
      .O_wr_bank(O_wr_bank),
      .O_rd_bank(O_rd_bank),
      .O_overrun(O_overrun)
   );

   typedef struct packed {
      logic          cmd;
      logic [OW+1:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_cyc = -100;
   int   cmd_cnt = 0;
   int   seen_ovr = 0;

   // reference model state: frame-level view of banks and offsets
   int m_wb, m_rb, m_ld, m_wo, m_ro, m_ovr;
   bit m_wa, m_ra, m_lw;

   task automatic check(string name, longint act, longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_wb = 1; m_rb = 0; m_ld = 0;
      m_wo = 0; m_ro = 0; m_ovr = 0;
      m_wa = 0; m_ra = 0; m_lw = 0;
   endtask

   task automatic m_apply(bit rs, bit ws);
      if (rs) begin
         m_rb = m_ld; m_ro = 0; m_ra = 1;
      end
      if (ws) begin
         if (m_wa) m_ovr++;
         if (m_rb == m_ld) m_wb = (m_ld + 1) % 3;
         else for (int b = 0; b < 3; b++)
            if (b != m_rb && b != m_ld) m_wb = b;
         m_wo = 0; m_wa = 1;
      end
   endtask

   task automatic m_run(int lvl, int fre, int max_n);
      int n;
      bit wok, rok, w;
      n = 0;
      forever begin
         wok = m_wa && lvl >= BW;
         rok = m_ra && fre >= BW;
         if (!(wok || rok) || n == max_n) break;
         if (wok && lvl >= URG) w = 1;
         else if (wok && rok) w = !m_lw;
         else w = wok;
         m_lw = w;
         n++;
         if (w) begin
            exp_q.push_back('{cmd: 1'b1, addr: {2'(m_wb), OW'(m_wo)}});
            m_wo += BW;
            if (m_wo == FW) begin m_wa = 0; m_ld = m_wb; end
         end else begin
            exp_q.push_back('{cmd: 1'b0, addr: {2'(m_rb), OW'(m_ro)}});
            m_ro += BW;
            if (m_ro == FW) m_ra = 0;
         end
      end
   endtask

   always @(posedge I_clk) begin
      cyc <= cyc + 1;
      if (I_cmd_done && !I_rst) done_cyc <= cyc;
   end

   // monitor: pops the scoreboard on every command strobe
   always @(negedge I_clk) begin
      exp_t e;
      if (!I_rst) begin
         if (O_overrun) seen_ovr++;
         if (O_cmd_en) begin
            cmd_cnt++;
            check("cmd_gap_ge2", (cyc - done_cyc) >= 2, 1);
            if (exp_q.size() == 0) begin
               check("unexpected_cmd_addr", O_addr, -1);
            end else begin
               e = exp_q.pop_front();
               check("cmd", O_cmd, e.cmd);
               check("addr", O_addr, e.addr);
               check("wr_grant", O_wr_grant, e.cmd);
               check("rd_grant", O_rd_grant, !e.cmd);
            end
         end
      end
   end

   // controller model: done pulse 5 cycles after the strobe
   initial begin
      int cnt;
      cnt = 0;
      I_cmd_done = 1'b0;
      forever begin
         @(negedge I_clk);
         I_cmd_done = 1'b0;
         if (I_rst) cnt = 0;
         else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) I_cmd_done = 1'b1;
            end
            if (O_cmd_en) cnt = 5;
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge I_clk);
   endtask

   task automatic pulse(bit rs, bit ws);
      @(negedge I_clk);
      I_rd_frame_start = rs;
      I_wr_frame_start = ws;
      @(negedge I_clk);
      I_rd_frame_start = 1'b0;
      I_wr_frame_start = 1'b0;
   endtask

   task automatic wait_quiet();
      int quiet;
      quiet = 0;
      for (int i = 0; i < 3000 && quiet < 4; i++) begin
         @(negedge I_clk);
         if (exp_q.size() == 0 && !O_wr_grant && !O_rd_grant) quiet++;
         else quiet = 0;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   task automatic check_banks(string tag);
      check({tag, "_wr_bank"}, O_wr_bank, m_wb);
      check({tag, "_rd_bank"}, O_rd_bank, m_rb);
      check({tag, "_overruns"}, seen_ovr, m_ovr);
   endtask

   task automatic phase(bit rs, bit ws, int lvl, int fre);
      I_wr_fifo_level = '0;
      I_rd_fifo_free = '0;
      pulse(rs, ws);
      tick(3);
      m_apply(rs, ws);
      check_banks("phase");
      I_wr_fifo_level = FWD'(lvl);
      I_rd_fifo_free = FWD'(fre);
      m_run(lvl, fre, -1);
      wait_quiet();
   endtask

   task automatic check_reset(string tag);
      check({tag, "_cmd_en"}, O_cmd_en, 0);
      check({tag, "_cmd"}, O_cmd, 0);
      check({tag, "_addr"}, O_addr, 0);
      check({tag, "_wr_grant"}, O_wr_grant, 0);
      check({tag, "_rd_grant"}, O_rd_grant, 0);
      check({tag, "_overrun"}, O_overrun, 0);
      check({tag, "_wr_bank"}, O_wr_bank, 1);
      check({tag, "_rd_bank"}, O_rd_bank, 0);
   endtask

   initial begin
      int n, c0;
      bit rs, ws;
      I_rst = 1'b1;
      I_init_done = 1'b0;
      I_wr_frame_start = 1'b0;
      I_rd_frame_start = 1'b0;
      I_wr_fifo_level = '0;
      I_rd_fifo_free = '0;
      m_reset();
      tick(2);
      check_reset("reset");
      I_rst = 1'b0;
      tick(2);

      // calibration gate: write side armed but controller not ready
      I_wr_fifo_level = 10'd20;
      pulse(0, 1);
      tick(20);
      check("no_cmd_before_init", cmd_cnt, 0);
      m_apply(0, 1);
      m_run(20, 0, -1);
      I_init_done = 1'b1;
      wait_quiet();
      I_init_done = 1'b0;

      // completed frame becomes the displayed one
      phase(1, 0, 0, 0);
      check("rd_bank_after_frame", O_rd_bank, 1);

      // round-robin, then urgent writes
      phase(0, 1, 20, 20);
      phase(1, 1, 50, 20);

      // overrun: restart the camera frame after two bursts
      I_wr_fifo_level = '0;
      I_rd_fifo_free = '0;
      pulse(0, 1);
      tick(3);
      m_apply(0, 1);
      check_banks("ovr_pre");
      m_run(20, 0, 2);
      I_wr_fifo_level = 10'd20;
      n = 0;
      for (int i = 0; i < 500 && n < 2; i++) begin
         @(posedge I_clk);
         if (I_cmd_done) n++;
      end
      check("ovr_two_bursts", n, 2);
      @(negedge I_clk);
      I_wr_fifo_level = '0;
      I_wr_frame_start = 1'b1;
      @(negedge I_clk);
      I_wr_frame_start = 1'b0;
      tick(3);
      m_apply(0, 1);
      check_banks("ovr_post");
      check("ovr_wr_ne_rd", O_wr_bank != 2'(m_rb), 1);
      check("ovr_wr_ne_done", O_wr_bank != 2'(m_ld), 1);
      I_wr_fifo_level = 10'd20;
      m_run(20, 0, -1);
      wait_quiet();

      // read frame restart latched during a burst
      I_wr_fifo_level = '0;
      I_rd_fifo_free = '0;
      pulse(1, 0);
      tick(3);
      m_apply(1, 0);
      m_run(0, 20, 2);
      I_rd_fifo_free = 10'd20;
      n = 0;
      for (int i = 0; i < 500 && n < 2; i++) begin
         @(negedge I_clk);
         if (O_cmd_en) n++;
      end
      check("pend_two_cmds", n, 2);
      I_rd_frame_start = 1'b1;
      @(negedge I_clk);
      I_rd_frame_start = 1'b0;
      m_apply(1, 0);
      m_run(0, 20, -1);
      wait_quiet();
      check_banks("pend");

      for (int k = 0; k < 12; k++) begin
         rs = 1'($urandom % 2);
         ws = rs ? 1'($urandom % 2) : 1'b1;
         phase(rs, ws, $urandom_range(0, 63), $urandom_range(0, 40));
      end

      // asynchronous reset in the middle of a burst
      I_wr_fifo_level = '0;
      I_rd_fifo_free = '0;
      pulse(0, 1);
      tick(3);
      m_apply(0, 1);
      m_run(20, 0, 1);
      I_wr_fifo_level = 10'd20;
      n = 0;
      for (int i = 0; i < 500 && n < 1; i++) begin
         @(negedge I_clk);
         if (O_cmd_en) n++;
      end
      check("rst_burst_started", n, 1);
      tick(2);
      check("rst_in_wait_grant", O_wr_grant, 1);
      #1 I_rst = 1'b1;
      #1 check_reset("async");
      exp_q.delete();
      m_reset();
      tick(2);
      I_rst = 1'b0;
      c0 = cmd_cnt;
      pulse(0, 1);
      tick(15);
      check("init_after_reset", cmd_cnt, c0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
